pc_sequencer: RTL

- Parametrised fetch-stage program counter for the MIPS pipeline.
- Holds the PC and a run-control FSM for continuous, single-step and halted operation, driven by the debug unit.
- Selects the next PC by fixed priority from exception, branch, jump, stall and sequential sources, and captures the EPC.
- Replaces the fixed 32-bit PC register. When disabled, the PC is held rather than cleared.

---
 rtl/pc_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with a run-control FSM (IDLE/RUN/STEP/HALTED) and a fixed-priority next-PC select.
// Optional fetch counter on o_icount is built when PC_ICOUNT_EN is defined.
module pc_sequencer #(
    parameter int              PC_W         = 32,
    parameter int              PC_STEP      = 4,
    parameter logic [PC_W-1:0] RESET_VECTOR = '0,
    parameter logic [PC_W-1:0] EXC_VECTOR   = PC_W'(32'h80),
    parameter int              CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_mode,
    input  logic             i_step,
    input  logic             i_stall,
    input  logic             i_jump_en,
    input  logic [PC_W-1:0]  i_jump_trgt,
    input  logic             i_branch_en,
    input  logic [PC_W-1:0]  i_branch_trgt,
    input  logic             i_exc,
    input  logic             i_halt,
    output logic [PC_W-1:0]  o_pc,
    output logic [PC_W-1:0]  o_pc_next,
    output logic             o_fetch_valid,
    output logic             o_running,
    output logic             o_halted,
    output logic [PC_W-1:0]  o_epc,
    output logic [CNT_W-1:0] o_icount
);

    typedef enum logic [1:0] {IDLE, RUN, STEP, HALTED} state_t;

    localparam logic [PC_W-1:0] STEP_INC   = PC_W'(PC_STEP);
    localparam logic [PC_W-1:0] ALIGN_MASK = ~(PC_W'(PC_STEP - 1));

    function automatic logic [PC_W-1:0] align_trgt(input logic [PC_W-1:0] trgt);
        return trgt & ALIGN_MASK;
    endfunction

    state_t          state;
    state_t          state_nxt;
    logic            active;
    logic            halt_acc;
    logic            pc_wr;
    logic            epc_wr;
    logic [PC_W-1:0] pc_nxt;

    assign active    = (state == RUN) || (state == STEP);
    // A halt only sticks when nothing with higher priority claims the cycle.
    assign halt_acc  = active && i_halt && !i_exc && !i_branch_en && !i_jump_en && !i_stall;
    assign o_pc_next = o_pc + STEP_INC;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_en) state_nxt = i_mode ? STEP : RUN;
            RUN:     if (halt_acc) state_nxt = HALTED;
                     else if (!i_en) state_nxt = IDLE;
                     else if (i_mode) state_nxt = STEP;
            STEP:    if (halt_acc) state_nxt = HALTED;
                     else if (!i_en) state_nxt = IDLE;
                     else if (!i_mode) state_nxt = RUN;
            default: state_nxt = HALTED;
        endcase
    end

    always_comb begin
        o_running = active;
        o_halted  = (state == HALTED);
    end

    always_comb begin
        pc_nxt = o_pc;
        pc_wr  = 1'b0;
        epc_wr = 1'b0;
        if (active) begin
            if (i_exc) begin
                pc_nxt = EXC_VECTOR;
                pc_wr  = 1'b1;
                epc_wr = 1'b1;
            end else if (i_branch_en) begin
                pc_nxt = align_trgt(i_branch_trgt);
                pc_wr  = 1'b1;
            end else if (i_jump_en) begin
                pc_nxt = align_trgt(i_jump_trgt);
                pc_wr  = 1'b1;
            end else if (!i_stall && !i_halt && (state == RUN || i_step)) begin
                pc_nxt = o_pc + STEP_INC;
                pc_wr  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_pc          <= RESET_VECTOR;
            o_epc         <= '0;
            o_fetch_valid <= 1'b0;
        end else begin
            if (pc_wr)  o_pc  <= pc_nxt;
            if (epc_wr) o_epc <= o_pc;
            o_fetch_valid <= pc_wr;
        end
    end

`ifdef PC_ICOUNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + CNT_W'(1);
    endfunction

    logic [CNT_W-1:0] icount;

    always_ff @(posedge clk) begin
        if (rst)        icount <= '0;
        else if (pc_wr) icount <= sat_inc(icount);
    end

    assign o_icount = icount;
`else
    assign o_icount = '0;
`endif

endmodule
